// File: rtl/counter_threebit_pkg.sv
// rtl/counter_threebit_pkg.sv - shared types and constants for the three-bit counter
//
// Holds the controller state enum and the counter width so the top and the
// adder agree on sizing.

package counter_threebit_pkg;

    localparam int CNT_W = 3;

    // Value q is clamped to when a carry occurs in the saturating build.
    localparam logic [CNT_W-1:0] CNT_MAX = 3'h7;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        HALT = 2'd2
    } state_t;

endpackage

// File: rtl/adder_threebit.sv
// rtl/adder_threebit.sv - three-bit combinational adder with carry-out
//
// Ports:
//   a    in  [CNT_W-1:0]  first operand (current count)
//   b    in  [CNT_W-1:0]  second operand (step)
//   s    out [CNT_W-1:0]  sum modulo 2**CNT_W
//   cout out 1            carry out of the top bit

module adder_threebit
    import counter_threebit_pkg::*;
(
    input  logic [CNT_W-1:0] a,
    input  logic [CNT_W-1:0] b,
    output logic [CNT_W-1:0] s,
    output logic             cout
);

    assign {cout, s} = {1'b0, a} + {1'b0, b};

endmodule

// File: rtl/counter_threebit.sv
// rtl/counter_threebit.sv - start/stop three-bit step counter with carry pulse and sticky overflow
//
// Build option: define COUNTER_THREEBIT_SATURATE_EN to clamp q at 7 and park
// in HALT on a carry; otherwise q wraps and HALT is never entered.
//
// Parameters:
//   RESET_VAL            value loaded into q on reset
// Ports:
//   clk       in   1  clock, all state changes on the rising edge
//   rst_n     in   1  synchronous active-low reset
//   start     in   1  request to enter RUN from IDLE
//   stop      in   1  request to leave RUN/HALT (wins over start)
//   load      in   1  load load_val into q (highest priority after reset)
//   load_val  in   3  value written on load
//   step      in   3  increment added each RUN cycle
//   clr_ovf   in   1  clear sticky overflow
//   q         out  3  registered count
//   busy      out  1  high while in RUN
//   tc        out  1  one-cycle pulse after a RUN add that carried
//   ovf       out  1  sticky overflow

module counter_threebit
    import counter_threebit_pkg::*;
#(
    parameter logic [CNT_W-1:0] RESET_VAL = 3'h0
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             stop,
    input  logic             load,
    input  logic [CNT_W-1:0] load_val,
    input  logic [CNT_W-1:0] step,
    input  logic             clr_ovf,
    output logic [CNT_W-1:0] q,
    output logic             busy,
    output logic             tc,
    output logic             ovf
);

    state_t           state;
    state_t           state_nxt;
    logic [CNT_W-1:0] q_nxt;
    logic             tc_nxt;
    logic             ovf_nxt;

    logic [CNT_W-1:0] sum;
    logic             cout;

    // The adder always sees the live count; its result is only used in RUN.
    adder_threebit u_adder (
        .a    (q),
        .b    (step),
        .s    (sum),
        .cout (cout)
    );

    always_comb begin
        state_nxt = state;
        q_nxt     = q;
        tc_nxt    = 1'b0;
        ovf_nxt   = ovf;

        if (clr_ovf) begin
            ovf_nxt = 1'b0;
        end

        if (load) begin
            // Load overrides counting: no add, no carry, overflow cleared.
            q_nxt   = load_val;
            ovf_nxt = 1'b0;
            if (state == HALT) begin
                state_nxt = IDLE;
            end
        end else begin
            case (state)
                RUN: begin
                    q_nxt  = sum;
                    tc_nxt = cout;
                    // A carry sets overflow even if clr_ovf is asserted.
                    if (cout) begin
                        ovf_nxt = 1'b1;
                    end
`ifdef COUNTER_THREEBIT_SATURATE_EN
                    if (cout) begin
                        q_nxt     = CNT_MAX;
                        state_nxt = HALT;
                    end
`endif
                    // stop still lets this cycle's add land, then leaves RUN.
                    if (stop) begin
                        state_nxt = IDLE;
                    end
                end
`ifdef COUNTER_THREEBIT_SATURATE_EN
                HALT: begin
                    if (stop) begin
                        state_nxt = IDLE;
                    end
                end
`endif
                default: begin
                    // IDLE; in the wrapping build an unreachable HALT decodes here too.
                    if (start && !stop) begin
                        state_nxt = RUN;
                    end
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= IDLE;
            q     <= RESET_VAL;
            tc    <= 1'b0;
            ovf   <= 1'b0;
        end else begin
            state <= state_nxt;
            q     <= q_nxt;
            tc    <= tc_nxt;
            ovf   <= ovf_nxt;
        end
    end

    assign busy = (state == RUN);

endmodule

// File: tb/tb_counter_threebit.sv
// tb/tb_counter_threebit.sv - self-checking bench for counter_threebit

module tb_counter_threebit;

    logic       clk;
    logic       rst_n;
    logic       start;
    logic       stop;
    logic       load;
    logic [2:0] load_val;
    logic [2:0] step;
    logic       clr_ovf;
    logic [2:0] q;
    logic       busy;
    logic       tc;
    logic       ovf;

    int vectors;
    int miscompares;

    // Reference model: mode 0 = idle, 1 = counting, 2 = parked at max.
    int m_q;
    int m_mode;
    int m_tc;
    int m_ovf;

    counter_threebit #(.RESET_VAL(3'h0)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .start    (start),
        .stop     (stop),
        .load     (load),
        .load_val (load_val),
        .step     (step),
        .clr_ovf  (clr_ovf),
        .q        (q),
        .busy     (busy),
        .tc       (tc),
        .ovf      (ovf)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic compare_all();
        chk("q",    {5'd0, q},    8'(m_q));
        chk("busy", {7'd0, busy}, 8'(m_mode == 1));
        chk("tc",   {7'd0, tc},   8'(m_tc));
        chk("ovf",  {7'd0, ovf},  8'(m_ovf));
    endtask

    // Advance one clock: the model consumes the inputs applied before the edge,
    // then outputs are compared on the falling edge.
    task automatic tick();
        int  total;
        bit  carry;
        bit  sat;
`ifdef COUNTER_THREEBIT_SATURATE_EN
        sat = 1'b1;
`else
        sat = 1'b0;
`endif
        @(posedge clk);
        vectors++;
        if (!rst_n) begin
            m_q = 0; m_mode = 0; m_tc = 0; m_ovf = 0;
        end else if (load) begin
            m_q = int'(load_val); m_tc = 0; m_ovf = 0;
            if (m_mode == 2) m_mode = 0;
        end else if (m_mode == 1) begin
            total = m_q + int'(step);
            carry = (total >= 8);
            m_q   = (sat && carry) ? 7 : total % 8;
            m_tc  = carry;
            if (carry) m_ovf = 1;
            else if (clr_ovf) m_ovf = 0;
            if (stop) m_mode = 0;
            else if (sat && carry) m_mode = 2;
        end else begin
            m_tc = 0;
            if (clr_ovf) m_ovf = 0;
            if (m_mode == 2) begin
                if (stop) m_mode = 0;
            end else if (start && !stop) begin
                m_mode = 1;
            end
        end
        @(negedge clk);
        compare_all();
    endtask

    task automatic drive(input bit r, input bit s, input bit p, input bit l,
                         input logic [2:0] lv, input logic [2:0] st, input bit c);
        rst_n = r; start = s; stop = p; load = l; load_val = lv; step = st; clr_ovf = c;
    endtask

    initial begin
        vectors = 0; miscompares = 0;
        m_q = 0; m_mode = 0; m_tc = 0; m_ovf = 0;
        drive(1'b0, 1'b1, 1'b0, 1'b0, 3'h0, 3'h0, 1'b0);

        // Reset held two cycles with start asserted.
        tick(); tick();
        chk("rst_q", {5'd0, q}, 8'd0);
        chk("rst_busy", {7'd0, busy}, 8'd0);
        chk("rst_tc", {7'd0, tc}, 8'd0);
        chk("rst_ovf", {7'd0, ovf}, 8'd0);

`ifndef COUNTER_THREEBIT_SATURATE_EN
        // Wrap: 5,7,1,3 with step 2.
        drive(1'b1, 1'b0, 1'b0, 1'b1, 3'h5, 3'h2, 1'b0); tick();
        chk("wrap_load_q", {5'd0, q}, 8'd5);
        chk("wrap_model_q", 8'(m_q), 8'd5);
        drive(1'b1, 1'b1, 1'b0, 1'b0, 3'h0, 3'h2, 1'b0); tick();
        chk("wrap_enter_q", {5'd0, q}, 8'd5);
        chk("wrap_enter_busy", {7'd0, busy}, 8'd1);
        start = 1'b0; tick();
        chk("wrap_q7", {5'd0, q}, 8'd7);
        tick();
        chk("wrap_q1", {5'd0, q}, 8'd1);
        chk("wrap_tc", {7'd0, tc}, 8'd1);
        chk("wrap_ovf", {7'd0, ovf}, 8'd1);
        tick();
        chk("wrap_q3", {5'd0, q}, 8'd3);
        chk("wrap_tc_off", {7'd0, tc}, 8'd0);
        chk("wrap_ovf_sticky", {7'd0, ovf}, 8'd1);
        stop = 1'b1; tick();
        chk("stop_q", {5'd0, q}, 8'd5);
        chk("stop_busy", {7'd0, busy}, 8'd0);
`else
        // Saturate: 6 + 3 carries, clamps to 7 and parks.
        drive(1'b1, 1'b0, 1'b0, 1'b1, 3'h6, 3'h3, 1'b0); tick();
        drive(1'b1, 1'b1, 1'b0, 1'b0, 3'h0, 3'h3, 1'b0); tick();
        start = 1'b0; tick();
        chk("sat_q", {5'd0, q}, 8'd7);
        chk("sat_busy", {7'd0, busy}, 8'd0);
        chk("sat_tc", {7'd0, tc}, 8'd1);
        chk("sat_ovf", {7'd0, ovf}, 8'd1);
        start = 1'b1; tick(); tick();
        chk("sat_start_ignored", {7'd0, busy}, 8'd0);
        chk("sat_hold_q", {5'd0, q}, 8'd7);
        drive(1'b1, 1'b1, 1'b0, 1'b1, 3'h2, 3'h3, 1'b0); tick();
        chk("sat_load_q", {5'd0, q}, 8'd2);
        load = 1'b0; start = 1'b0; tick();
        chk("sat_idle_q", {5'd0, q}, 8'd2);
        chk("sat_idle_busy", {7'd0, busy}, 8'd0);
`endif

        // start and stop together in IDLE act as stop.
        drive(1'b1, 1'b1, 1'b1, 1'b0, 3'h0, 3'h1, 1'b0); tick();
        chk("startstop_busy", {7'd0, busy}, 8'd0);
        stop = 1'b0; step = 3'h0; tick();
        chk("run_busy", {7'd0, busy}, 8'd1);
        // Load beats counting in RUN.
        drive(1'b1, 1'b1, 1'b0, 1'b1, 3'h4, 3'h1, 1'b0); tick();
        chk("load_prio_q", {5'd0, q}, 8'd4);
        chk("load_prio_busy", {7'd0, busy}, 8'd1);

        // Overflow set wins over clear in the same cycle.
        drive(1'b1, 1'b0, 1'b0, 1'b1, 3'h7, 3'h1, 1'b0); tick();
        load = 1'b0; clr_ovf = 1'b1; tick();
        chk("race_ovf", {7'd0, ovf}, 8'd1);
        chk("race_tc", {7'd0, tc}, 8'd1);
        step = 3'h0; tick();
        chk("race_clr_ovf", {7'd0, ovf}, 8'd0);

        // Reset on a carry cycle abandons the add.
        drive(1'b1, 1'b0, 1'b1, 1'b0, 3'h0, 3'h0, 1'b0); tick();
        drive(1'b1, 1'b1, 1'b0, 1'b0, 3'h0, 3'h0, 1'b0); tick();
        drive(1'b1, 1'b0, 1'b0, 1'b1, 3'h7, 3'h0, 1'b0); tick();
        chk("midrun_busy", {7'd0, busy}, 8'd1);
        chk("midrun_q", {5'd0, q}, 8'd7);
        drive(1'b0, 1'b0, 1'b0, 1'b0, 3'h0, 3'h1, 1'b0); tick();
        chk("midrun_rst_q", {5'd0, q}, 8'd0);
        chk("midrun_rst_tc", {7'd0, tc}, 8'd0);
        chk("midrun_rst_ovf", {7'd0, ovf}, 8'd0);

        // Randomised traffic against the model.
        for (int i = 0; i < 3000; i++) begin
            drive($urandom_range(99) >= 2,
                  $urandom_range(99) < 35,
                  $urandom_range(99) < 12,
                  $urandom_range(99) < 8,
                  3'($urandom_range(7)),
                  ($urandom_range(99) < 10) ? 3'h0 : 3'($urandom_range(7)),
                  $urandom_range(99) < 20);
            tick();
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
